axi_wr_arbiter: RTL and testbench

- Shares one write-capable slave (AW/W/B channels) between N write masters.
- Selects a winner by round-robin and owns the slave for one whole write burst: address, all data beats, then the response.
- Sits between the master write FSMs and the memory/slave write port.
- The read path is not touched.

---
 rtl/axi_wr_arbiter_pkg.sv | 13 +
 rtl/axi_wr_arbiter_rr_pick.sv | 28 ++
 rtl/axi_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_arbiter_pkg.sv
// arb_pkg: state encoding, default widths and AW payload field offsets shared by axi_wr_arbiter and rr_pick
package arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
   localparam int N_DEF      = 2;
   localparam int ADDR_W_DEF = 8;
   localparam int LEN_W_DEF  = 4;
   localparam int ID_W_DEF   = 4;
   localparam int DATA_W_DEF = 8;
   localparam int RESP_W_DEF = 5;
   localparam int PAY_ADDR_LSB = 8;
   localparam int PAY_LEN_LSB  = 4;
   localparam int PAY_ID_LSB   = 0;
endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; req = requests, last_winner = previous owner, winner/valid = chosen index
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_winner,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;
   // Walk from farthest to nearest so the requester closest after last_winner is the final assignment.
   always_comb begin
      winner = last_winner;
      valid  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = N; k >= 1; k--) begin
         sum = {1'b0, last_winner} + (IDX_W+1)'(k);
         idx = IDX_W'(sum >= (IDX_W+1)'(N) ? sum - (IDX_W+1)'(N) : sum);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin sharing of one AXI write slave (AW/W/B) among N masters, one whole burst per grant.
//   m_awvalid/m_aw_pay/m_awready, m_wvalid/m_wdata/m_wlast/m_wready, m_bvalid/m_bresp/m_bready : flattened master ports
//   s_aw*/s_w*/s_b* : slave port; grant : one-hot owner; busy : not IDLE; beat_err : sticky burst-length error
//   Optional macro ARB_BEAT_CHECK_EN adds a beat counter that flags and terminates mis-sized bursts.
module axi_wr_arbiter import arb_pkg::*; #(
   parameter int N      = N_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RESP_W = RESP_W_DEF,
   parameter int PAY_W  = ADDR_W + LEN_W + ID_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        m_awvalid,
   input  logic [N*PAY_W-1:0]  m_aw_pay,
   output logic [N-1:0]        m_awready,
   input  logic [N-1:0]        m_wvalid,
   input  logic [N*DATA_W-1:0] m_wdata,
   input  logic [N-1:0]        m_wlast,
   output logic [N-1:0]        m_wready,
   output logic [N-1:0]        m_bvalid,
   output logic [N*RESP_W-1:0] m_bresp,
   input  logic [N-1:0]        m_bready,
   output logic                s_awvalid,
   output logic [PAY_W-1:0]    s_aw_pay,
   input  logic                s_awready,
   output logic                s_wvalid,
   output logic [DATA_W-1:0]   s_wdata,
   output logic                s_wlast,
   input  logic                s_wready,
   input  logic                s_bvalid,
   input  logic [RESP_W-1:0]   s_bresp,
   output logic                s_bready,
   output logic [N-1:0]        grant,
   output logic                busy,
   output logic                beat_err
);
   localparam int IDX_W = $clog2(N);
   state_t             state_q, state_d;
   logic [N-1:0]       grant_q, grant_d;
   logic [PAY_W-1:0]   pay_q, pay_d;
   logic [IDX_W-1:0]   g_q, g_d, last_q, last_d, pick;
   logic               pick_valid, beat;
   logic [PAY_W-1:0]   ap [N];
   logic [DATA_W-1:0]  wd [N];
   genvar i;
   for (i = 0; i < N; i++) begin : g_split
      assign ap[i] = m_aw_pay[i*PAY_W +: PAY_W];
      assign wd[i] = m_wdata[i*DATA_W +: DATA_W];
   end
   rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
      .req         (m_awvalid),
      .last_winner (last_q),
      .winner      (pick),
      .valid       (pick_valid)
   );
   assign s_awvalid = state_q == ADDR;
   assign m_awready = (state_q == ADDR && s_awready) ? grant_q : '0;
   assign s_wvalid  = state_q == DATA && m_wvalid[g_q];
   assign s_wdata   = state_q == DATA ? wd[g_q] : '0;
   assign s_wlast   = state_q == DATA && m_wlast[g_q];
   assign m_wready  = (state_q == DATA && s_wready) ? grant_q : '0;
   assign s_bready  = state_q == RESP && m_bready[g_q];
   assign m_bvalid  = (state_q == RESP && s_bvalid) ? grant_q : '0;
   assign m_bresp   = {N{s_bresp}};
   assign s_aw_pay  = pay_q;
   assign grant     = grant_q;
   assign busy      = state_q != IDLE;
   assign beat      = s_wvalid & s_wready;
`ifdef ARB_BEAT_CHECK_EN
   logic [LEN_W:0] cnt_q, cnt_d, len;
   logic           err_q, err_d, no_last, bad_last;
   assign len      = {1'b0, pay_q[ID_W +: LEN_W]};
   // cnt_q counts beats already accepted, so the current beat is number cnt_q and the last must be number len.
   assign no_last  = beat & ~s_wlast & (cnt_q == len);
   assign bad_last = beat & s_wlast & (cnt_q != len);
   assign beat_err = err_q;
`else
   assign beat_err = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      pay_d   = pay_q;
      g_d     = g_q;
      last_d  = last_q;
`ifdef ARB_BEAT_CHECK_EN
      cnt_d   = beat ? cnt_q + 1'b1 : cnt_q;
      err_d   = err_q | bad_last | no_last;
`endif
      case (state_q)
         IDLE: if (pick_valid) begin
            grant_d = N'(1) << pick;
            pay_d   = ap[pick];
            g_d     = pick;
            state_d = ADDR;
         end
         ADDR: if (s_awready) begin
            state_d = DATA;
`ifdef ARB_BEAT_CHECK_EN
            cnt_d   = '0;
`endif
         end
`ifdef ARB_BEAT_CHECK_EN
         DATA: state_d = (beat & (s_wlast | no_last)) ? RESP : DATA;
`else
         DATA: state_d = (beat & s_wlast) ? RESP : DATA;
`endif
         RESP: if (s_bvalid & s_bready) begin
            last_d  = g_q;
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         pay_q   <= '0;
         g_q     <= '0;
         last_q  <= IDX_W'(N-1);
`ifdef ARB_BEAT_CHECK_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         pay_q   <= pay_d;
         g_q     <= g_d;
         last_q  <= last_d;
`ifdef ARB_BEAT_CHECK_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized scoreboard bench for axi_wr_arbiter with a queue-based reference model
module tb_axi_wr_arbiter;
   localparam int N = 2, ADDR_W = 8, LEN_W = 4, ID_W = 4, DATA_W = 8, RESP_W = 5;
   localparam int PAY_W = ADDR_W + LEN_W + ID_W;
   logic clk = 1'b0, rst;
   logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready, grant;
   logic [N*PAY_W-1:0] m_aw_pay;
   logic [N*DATA_W-1:0] m_wdata;
   logic [N*RESP_W-1:0] m_bresp;
   logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready, busy, beat_err;
   logic [PAY_W-1:0] s_aw_pay;
   logic [DATA_W-1:0] s_wdata;
   logic [RESP_W-1:0] s_bresp;
   axi_wr_arbiter #(.N(N), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W), .RESP_W(RESP_W)) dut (
      .clk(clk), .rst(rst),
      .m_awvalid(m_awvalid), .m_aw_pay(m_aw_pay), .m_awready(m_awready),
      .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
      .s_awvalid(s_awvalid), .s_aw_pay(s_aw_pay), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
      .grant(grant), .busy(busy), .beat_err(beat_err)
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   int last_w = N - 1;
   logic [PAY_W+N-1:0]  q_aw [$];
   logic [DATA_W:0]     q_w [$];
   logic [RESP_W+N-1:0] q_b [$];
   logic [PAY_W+N-1:0]  ea;
   logic [DATA_W:0]     ew;
   logic [RESP_W+N-1:0] eb;
   logic [N*RESP_W-1:0] rep;
`ifdef ARB_BEAT_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic fail(input string name, input string what);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, what);
   endtask
   // Winner = first requester after the last served master, wrapping modulo N.
   function automatic int rr(input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) if (req[(last_w + k) % N]) return (last_w + k) % N;
      return -1;
   endfunction
   function automatic logic [PAY_W-1:0] rpay();
      return {8'($urandom), 4'($urandom_range(0, 3)), 4'($urandom)};
   endfunction
   task automatic quiesce();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      q_aw.delete(); q_w.delete(); q_b.delete();
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         if (s_awvalid && s_awready) begin
            if (q_aw.size() == 0) fail("aw_extra", "AW handshake seen, none expected");
            else begin
               ea = q_aw.pop_front();
               chk("aw_pay", 32'(s_aw_pay), 32'(ea[PAY_W+N-1:N]));
               chk("aw_grant", 32'(grant), 32'(ea[N-1:0]));
            end
         end
         if (s_wvalid && s_wready) begin
            if (q_w.size() == 0) fail("w_extra", "W beat seen, none expected");
            else begin
               ew = q_w.pop_front();
               chk("w_data", 32'(s_wdata), 32'(ew[DATA_W-1:0]));
               chk("w_last", 32'(s_wlast), 32'(ew[DATA_W]));
            end
         end
         if (s_bvalid && s_bready) begin
            if (q_b.size() == 0) fail("b_extra", "B handshake seen, none expected");
            else begin
               eb = q_b.pop_front();
               for (int j = 0; j < N; j++) rep[j*RESP_W +: RESP_W] = eb[RESP_W+N-1:N];
               chk("b_valid", 32'(m_bvalid), 32'(eb[N-1:0]));
               chk("b_resp", 32'(m_bresp), 32'(rep));
            end
         end
         chk("isolation", 32'((m_awready | m_wready | m_bvalid) & ~grant), 0);
         chk("grant_onehot", 32'($countones(grant) <= 1), 1);
      end
   end
   task automatic burst(input logic [N-1:0] req, input logic [N*PAY_W-1:0] pays, input int wlast_at,
                        input int d_base, input int bresp_fix, input int bdelay, input bit use_pat, input int rst_after);
      int w, len, k;
      bit ok;
      logic [N-1:0] oh;
      logic [PAY_W-1:0] pw;
      logic [RESP_W-1:0] br;
      logic [DATA_W-1:0] data [16];
      logic [5:0] pat;
      pat = 6'b101101;
      @(negedge clk);
      w = rr(req);
      oh = '0;
      oh[w] = 1'b1;
      pw = pays[w*PAY_W +: PAY_W];
      len = int'(pw[ID_W +: LEN_W]);
      if (wlast_at < 0) wlast_at = len;
      for (int j = 0; j <= wlast_at; j++) begin
         data[j] = d_base >= 0 ? DATA_W'(d_base + j) : DATA_W'($urandom);
         q_w.push_back({j == wlast_at, data[j]});
      end
      br = bresp_fix >= 0 ? RESP_W'(bresp_fix) : RESP_W'($urandom);
      q_aw.push_back({pw, oh});
      q_b.push_back({br, oh});
      m_aw_pay = pays;
      m_awvalid = req;
      ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
         s_awready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (c == 0) chk("aw_latency", 32'(s_awvalid), 1);
         ok = s_awvalid && s_awready;
         @(posedge clk); #1;
      end
      m_awvalid = req & ~oh;
      s_awready = 1'b0;
      if (!ok) begin fail("aw_timeout", "no AW handshake within 50 cycles, one required"); quiesce(); return; end
      k = 0;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         if (rst_after >= 0 && k == rst_after) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_busy", 32'(busy), 0);
            chk("rst_mid_grant", 32'(grant), 0);
            chk("rst_mid_pay", 32'(s_aw_pay), 0);
            chk("rst_mid_outs", 32'({s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready, m_bvalid}), 0);
            quiesce();
            last_w = N - 1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         m_wvalid = (use_pat || $urandom_range(0, 3) != 0) ? oh : '0;
         m_wvalid = m_wvalid | (~oh & N'($urandom));
         m_wdata = {N{DATA_W'($urandom)}};
         m_wdata[w*DATA_W +: DATA_W] = data[k];
         m_wlast = '0;
         m_wlast[w] = k == wlast_at;
         s_wready = use_pat ? pat[c % 6] : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (s_wvalid && s_wready) begin
            k++;
            ok = k > wlast_at;
         end
         @(posedge clk); #1;
      end
      m_wvalid = '0;
      m_wlast = '0;
      s_wready = 1'b0;
      if (!ok) begin fail("w_timeout", $sformatf("only %0d beats in 200 cycles, %0d required", k, wlast_at + 1)); quiesce(); return; end
      s_bvalid = 1'b1;
      s_bresp = br;
      m_bready = '0;
      for (int d = 0; d < bdelay; d++) begin
         @(negedge clk);
         chk("resp_hold_busy", 32'(busy), 1);
         chk("resp_hold_bvalid", 32'(m_bvalid), 32'(oh));
         @(posedge clk); #1;
      end
      m_bready = '1;
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = s_bvalid && s_bready;
         @(posedge clk); #1;
      end
      s_bvalid = 1'b0;
      m_bready = '0;
      m_awvalid = '0;
      if (!ok) begin fail("b_timeout", "no B handshake within 20 cycles, one required"); quiesce(); return; end
      last_w = w;
      @(negedge clk);
      chk("idle_gap_busy", 32'(busy), 0);
      chk("idle_gap_grant", 32'(grant), 0);
      chk("w_leftover", 32'(q_w.size()), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: still running at time 200000, required to finish earlier");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1;
      m_aw_pay = '0; m_wdata = '0; s_bresp = '0;
      quiesce();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pay", 32'(s_aw_pay), 0);
      chk("rst_outs", 32'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 0);
      chk("rst_beat_err", 32'(beat_err), 0);
      rst = 1'b0;
      burst(2'b01, {16'h0000, 16'h2A03}, -1, 'h55, 0, 0, 1'b0, -1);
      repeat (4) burst(2'b11, {rpay(), rpay()}, -1, -1, -1, 0, 1'b0, -1);
      burst(2'b10, {16'h4C35, rpay()}, -1, 'hD0, -1, 0, 1'b1, -1);
      burst(2'b01, {rpay(), 16'h1000}, -1, -1, -1, 0, 1'b0, -1);
      burst(2'b10, {16'h7731, rpay()}, -1, -1, -1, 0, 1'b0, 2);
      burst(2'b11, {rpay(), rpay()}, -1, -1, -1, 0, 1'b0, -1);
      burst(2'b01, {rpay(), 16'h5521}, 1, -1, -1, 0, 1'b0, -1);
      chk("beat_err", 32'(beat_err), 32'(EXP_ERR));
      burst(2'b10, {rpay(), rpay()}, -1, -1, -1, 0, 1'b0, -1);
      chk("beat_err_sticky", 32'(beat_err), 32'(EXP_ERR));
      burst(2'b10, {rpay(), rpay()}, -1, -1, -1, 3, 1'b0, -1);
      repeat (12) burst(N'($urandom_range(1, (1 << N) - 1)), {rpay(), rpay()}, -1, -1, -1, $urandom_range(0, 2), 1'b0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
